wb_reg_subordinate: RTL and testbench
=====================================

Name: wb_reg_subordinate

Overview:
- Wishbone classic subordinate (responder) on the same bus that the team's CPU-side wishbone manager drives.
- Decodes a configurable address window and serves a small register bank: one control word driven to user logic, one read-only status word, and scratch words.
- Inserts a configurable number of wait states, supports byte-lane writes, and never stalls the manager: out-of-window accesses are still acknowledged.

Parameters:
BASE_ADDR, 32'h3000_0000, byte address of word 0; must be 4-byte aligned.
NUM_WORDS, 16, number of 32-bit words in window (>=3, power of 2).
WAIT_STATES, 1, cycles inserted between request capture and ACK (0..15).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
CYC_I  input  1  bus cycle active
STB_I  input  1  strobe, request valid
WE_I  input  1  1 = write, 0 = read
ADR_I  input  32  byte address
DAT_I  input  32  write data
SEL_I  input  4  byte-lane enables, bit i -> DAT_I[8i+7:8i]
DAT_O  output  32  read data, valid only while ACK_O=1
ACK_O  output  1  one-cycle acknowledge
ctrl_o  output  32  contents of word 0
status_i  input  32  returned on reads of word 1
wr_strobe_o  output  1  one-cycle pulse on a committed register write
wr_idx_o  output  $clog2(NUM_WORDS)  word index of committed write, valid with wr_strobe_o

Behaviour:
- Reset (async, rst=1): FSM->IDLE; all bank words, ctrl_o, DAT_O, ACK_O, wr_strobe_o, wr_idx_o, wait counter = 0. Reset mid-transaction drops the request with no ACK and no write.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on an edge with CYC_I&STB_I=1, latch ADR_I, DAT_I, SEL_I, WE_I. Go to WAIT if WAIT_STATES>0 and load the counter with WAIT_STATES-1. Otherwise go to ACK.
- WAIT: decrement the counter each edge; go to ACK when it is 0. If CYC_I=0 on any edge, return to IDLE (abort): no ACK, no write.
- ACK: ACK_O=1 for exactly one cycle, then IDLE unconditionally. A new request is sampled on the first IDLE edge.
- Latency: request sampled at edge N -> ACK_O high in the cycle after edge N+WAIT_STATES. This is WAIT_STATES+1 cycles of latency.
- Decode: in-window iff ADR_I[31:2] is in [BASE_ADDR[31:2], BASE_ADDR[31:2]+NUM_WORDS). Index = ADR_I[31:2]-BASE_ADDR[31:2]. ADR_I[1:0] is ignored.
- Writes are committed on the edge entering ACK:
  - Index 0 or >=2: each byte i with SEL_I[i]=1 is updated; bytes with SEL_I[i]=0 are unchanged.
  - wr_strobe_o=1 and wr_idx_o=index during the ACK cycle. SEL_I=0 still pulses wr_strobe_o (no data change).
  - Index 1 (status) is read-only: data is ignored, no strobe, ACK still given.
  - Out-of-window: ignored, no strobe, ACK given.
- Reads: DAT_O is registered on the edge entering ACK.
  - Index 1 returns status_i as sampled on that edge.
  - Other in-window indexes return the stored word; SEL_I is ignored (full word returned).
  - Out-of-window returns 32'h0.
- DAT_O is 0 in every cycle ACK_O=0 and during write ACKs.
- ctrl_o reflects word 0 combinationally from the register. A write to word 0 is visible on ctrl_o in the ACK cycle.
- CYC_I=1 with STB_I=0 is ignored. STB_I without CYC_I is ignored.
- Back-to-back requests: the manager drops STB_I on the edge ending ACK. If STB_I is still high at the next IDLE edge, that is a new transaction.

Test Plan:
- Reset, then write 32'hDEAD_BEEF with SEL=4'hF to 32'h3000_0008 (WAIT_STATES=1). Then read the same address -> write ACK 2 cycles after request; wr_strobe_o=1 and wr_idx_o=2 in the ACK cycle; read ACK returns DAT_O=32'hDEAD_BEEF.
- Write 32'h1122_3344 to word 0 with SEL=4'hF, then write 32'hAABB_CCDD with SEL=4'b0101 -> ctrl_o=32'h11BB_33DD; a read of 32'h3000_0000 returns the same value.
- Drive status_i=32'hCAFE_0001 and write 32'hFFFF_FFFF to 32'h3000_0004, then read it -> write ACKed with no wr_strobe_o; read returns 32'hCAFE_0001.
- Read 32'h3000_0040 and write 32'h2000_0000 -> both ACKed after 2 cycles; read DAT_O=0; no bank word changes; no strobe.
- Start a write to 32'h3000_000C and drop CYC_I during WAIT -> no ACK_O, word 3 stays 0, FSM returns to IDLE. Assert rst during WAIT of another request -> all outputs 0 immediately, ctrl_o=0.
- Two back-to-back reads of words 2 and 3 with STB_I re-asserted right after the first ACK -> two separate single-cycle ACKs, each 2 cycles after its own request, returning the correct data.

Source files
------------

// File: rtl/wb_reg_subordinate.sv
// Wishbone classic register-bank responder: control word, read-only status word,
// scratch words, programmable wait states and byte-lane writes.
module wb_reg_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_WORDS   = 16,
    parameter int          WAIT_STATES = 1,
    localparam int         IW          = $clog2(NUM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    input  logic [31:0]   ADR_I,
    input  logic [31:0]   DAT_I,
    input  logic [3:0]    SEL_I,
    output logic [31:0]   DAT_O,
    output logic          ACK_O,
    output logic [31:0]   ctrl_o,
    input  logic [31:0]   status_i,
    output logic          wr_strobe_o,
    output logic [IW-1:0] wr_idx_o
);

    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    typedef struct packed {
        logic        we;
        logic [29:0] word;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_req_t;

    state_t                       state, nxt;
    logic   [3:0]                 cnt;
    wb_req_t                      req, live, cur;
    logic   [NUM_WORDS-1:0][31:0] bank;
    logic                         commit;
    logic   [29:0]                word_off;
    logic                         in_win;
    logic   [IW-1:0]              idx;
    logic                         unused_bits;

    assign unused_bits = ^ADR_I[1:0];
    assign live        = '{we: WE_I, word: ADR_I[31:2], dat: DAT_I, sel: SEL_I};
    // With zero wait states the commit happens on the capture edge itself.
    assign cur         = (state == S_IDLE) ? live : req;
    assign word_off    = cur.word - BASE_W;
    assign in_win      = (cur.word >= BASE_W) && (word_off < 30'(NUM_WORDS));
    assign idx         = word_off[IW-1:0];
    assign ctrl_o      = bank[0];

    always_comb begin
        nxt    = state;
        commit = 1'b0;
        case (state)
            S_IDLE: if (CYC_I && STB_I) begin
                if (WAIT_STATES > 0) nxt = S_WAIT;
                else begin
                    nxt    = S_ACK;
                    commit = 1'b1;
                end
            end
            S_WAIT: begin
                if (!CYC_I) nxt = S_IDLE;
                else if (cnt == 4'd0) begin
                    nxt    = S_ACK;
                    commit = 1'b1;
                end
            end
            S_ACK:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req         <= '0;
            bank        <= '0;
            DAT_O       <= '0;
            ACK_O       <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_idx_o    <= '0;
        end else begin
            state       <= nxt;
            DAT_O       <= '0;
            ACK_O       <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_idx_o    <= '0;
            if (state == S_IDLE && CYC_I && STB_I) begin
                req <= live;
                if (WAIT_STATES > 0) cnt <= 4'(WAIT_STATES - 1);
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                ACK_O <= 1'b1;
                if (cur.we) begin
                    // Status word is read-only; out-of-window writes are dropped silently.
                    if (in_win && idx != IW'(1)) begin
                        for (int b = 0; b < 4; b++)
                            if (cur.sel[b]) bank[idx][8*b +: 8] <= cur.dat[8*b +: 8];
                        wr_strobe_o <= 1'b1;
                        wr_idx_o    <= idx;
                    end
                end else if (in_win) begin
                    DAT_O <= (idx == IW'(1)) ? status_i : bank[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_reg_subordinate.sv
// Randomized bench for wb_reg_subordinate against a word-array reference model.
module tb_wb_reg_subordinate;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int NW = 16;
    localparam int WS = 1;
    localparam int IW = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst;
    logic          CYC_I, STB_I, WE_I;
    logic [31:0]   ADR_I, DAT_I, DAT_O, ctrl_o, status_i;
    logic [3:0]    SEL_I;
    logic          ACK_O, wr_strobe_o;
    logic [IW-1:0] wr_idx_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [NW];

    wb_reg_subordinate #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
        .ctrl_o(ctrl_o), .status_i(status_i), .wr_strobe_o(wr_strobe_o),
        .wr_idx_o(wr_idx_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus transfer; extra = idle edges before the request can be sampled
    // (1 when driven during the previous ACK cycle).
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit keep, input int extra);
        int          n;
        logic [31:0] off;
        bit          inw, exp_stb;
        logic [31:0] exp_rd;
        off     = (adr >> 2) - (BASE >> 2);
        inw     = ((adr >> 2) >= (BASE >> 2)) && (off < NW);
        exp_stb = we && inw && off != 1;
        exp_rd  = (!we && inw) ? ((off == 1) ? status_i : mem[off]) : 32'h0;
        if (exp_stb)
            for (int b = 0; b < 4; b++)
                if (sel[b]) mem[off][8*b +: 8] = dat[8*b +: 8];
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ACK_O && n < 20);
        chk("ack_latency", n, WS + 1 + extra);
        chk("ack", {31'b0, ACK_O}, 1);
        chk("wr_strobe", {31'b0, wr_strobe_o}, {31'b0, exp_stb});
        if (exp_stb) chk("wr_idx", 32'(wr_idx_o), off);
        chk("dat_o", DAT_O, exp_rd);
        chk("ctrl_o", ctrl_o, mem[0]);
        if (!keep) begin
            CYC_I = 1'b0; STB_I = 1'b0;
            @(posedge clk); #1;
            chk("ack_single", {31'b0, ACK_O}, 0);
            chk("dat_idle", DAT_O, 0);
            chk("strobe_idle", {31'b0, wr_strobe_o}, 0);
        end
    endtask

    initial begin
        bit          saw;
        logic [31:0] a, d;
        rst = 1'b1; CYC_I = 0; STB_I = 0; WE_I = 0; ADR_I = 0; DAT_I = 0; SEL_I = 0;
        status_i = 32'h0;
        foreach (mem[i]) mem[i] = 32'h0;
        #1;
        chk("rst_ack", {31'b0, ACK_O}, 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_ctrl", ctrl_o, 0);
        chk("rst_strobe", {31'b0, wr_strobe_o}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed scenarios
        xfer(1, 32'h3000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0);
        xfer(0, 32'h3000_0008, 32'h0, 4'hF, 0, 0);
        xfer(1, 32'h3000_0000, 32'h1122_3344, 4'hF, 0, 0);
        xfer(1, 32'h3000_0000, 32'hAABB_CCDD, 4'b0101, 0, 0);
        chk("ctrl_merge", ctrl_o, 32'h11BB_33DD);
        xfer(0, 32'h3000_0000, 32'h0, 4'h0, 0, 0);
        status_i = 32'hCAFE_0001;
        xfer(1, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF, 0, 0);
        xfer(0, 32'h3000_0004, 32'h0, 4'hF, 0, 0);
        xfer(0, 32'h3000_0040, 32'h0, 4'hF, 0, 0);
        xfer(1, 32'h2000_0000, 32'h5555_AAAA, 4'hF, 0, 0);
        xfer(1, 32'h3000_0010, 32'h1234_5678, 4'h0, 0, 0);

        // Abort during WAIT
        CYC_I = 1; STB_I = 1; WE_I = 1; ADR_I = 32'h3000_000C; DAT_I = 32'h0BAD_F00D; SEL_I = 4'hF;
        @(posedge clk); #1;
        CYC_I = 0; STB_I = 0;
        saw = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ACK_O || wr_strobe_o) saw = 1;
        end
        chk("abort_no_ack", {31'b0, saw}, 0);
        xfer(0, 32'h3000_000C, 32'h0, 4'hF, 0, 0);

        // Back-to-back reads with STB re-asserted straight after the first ACK
        xfer(0, 32'h3000_0008, 32'h0, 4'hF, 1, 0);
        xfer(0, 32'h3000_000C, 32'h0, 4'hF, 0, 1);

        // Reset in the middle of a write
        CYC_I = 1; STB_I = 1; WE_I = 1; ADR_I = 32'h3000_0000; DAT_I = 32'h7777_7777; SEL_I = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("mid_rst_ack", {31'b0, ACK_O}, 0);
        chk("mid_rst_ctrl", ctrl_o, 0);
        chk("mid_rst_dat", DAT_O, 0);
        foreach (mem[i]) mem[i] = 32'h0;
        CYC_I = 0; STB_I = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ack", {31'b0, ACK_O}, 0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 5))
                0:       a = BASE - 32'(4 * $urandom_range(1, 4));
                1:       a = BASE + 32'(4 * (NW + $urandom_range(0, 3)));
                default: a = BASE + 32'(4 * $urandom_range(0, NW - 1));
            endcase
            a[1:0]   = 2'($urandom);
            d        = $urandom;
            status_i = $urandom;
            xfer(1'($urandom), a, d, 4'($urandom), 0, 0);
        end
        for (int i = 0; i < NW; i++) xfer(0, BASE + 32'(4 * i), 32'h0, 4'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
